// File: rtl/nios2_ocimem_pkg.sv
// Shared definitions for the OCI debug-RAM bridge:
// jdo field positions and the JTAG/CPU state encodings.
package nios2_ocimem_pkg;

    localparam int JDO_W        = 38;
    localparam int JDO_RD_BIT   = 35;
    localparam int JDO_WD_LSB   = 3;
    localparam int JDO_WD_MSB   = 34;
    localparam int JDO_ADDR_LSB = 17;

    typedef enum logic {
        J_IDLE = 1'b0,
        J_RD   = 1'b1
    } j_state_e;

    typedef enum logic {
        C_IDLE = 1'b0,
        C_RD   = 1'b1
    } c_state_e;

endpackage

// File: rtl/nios2_system_nios2_ocimem_ram.sv
// Single-port debug RAM: synchronous read with one cycle latency,
// per-byte write enables. Contents are never reset.
module nios2_system_nios2_ocimem_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       q
);

    logic [31:0] mem [2**ADDR_W];

    // q only moves on reads so it holds the last read word for the consumer.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/nios2_system_nios2_ocimem_bridge.sv
// Debug-RAM bridge: JTAG monitor access (MonAReg/MonDReg) and an
// Avalon-MM CPU slave sharing one single-port RAM; JTAG wins the port.
module nios2_system_nios2_ocimem_bridge
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              waitrequest
);

    j_state_e          j_state;
    c_state_e          c_state;
    logic [ADDR_W-1:0] mon_areg;
    logic [ADDR_W-1:0] rd_addr;

    logic              j_idle;
    logic              any_pulse;
    logic              do_a;
    logic              do_b;
    logic              do_na;
    logic              jtag_own;
    logic              cpu_wr;
    logic              cpu_rd;
    logic              bypass;
    logic [ADDR_W-1:0] jdo_addr;
    logic [31:0]       jdo_wdata;

    logic              ram_en;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_q;

    logic              unused_jdo;

    assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WD_LSB-1:0]};

    assign jdo_addr  = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_wdata = jdo[JDO_WD_MSB:JDO_WD_LSB];

    assign j_idle    = (j_state == J_IDLE);
    assign any_pulse = take_action_ocimem_a | take_action_ocimem_b
                     | take_no_action_ocimem_a;
    assign do_a      = j_idle & take_action_ocimem_a;
    assign do_b      = j_idle & take_action_ocimem_b & ~take_action_ocimem_a;
    assign do_na     = j_idle & take_no_action_ocimem_a
                     & ~take_action_ocimem_a & ~take_action_ocimem_b;
    assign jtag_own  = j_idle & any_pulse;

    assign cpu_wr    = (c_state == C_IDLE) & write & ~jtag_own;
    assign cpu_rd    = (c_state == C_IDLE) & read & ~write & ~jtag_own;

    // A JTAG write landing on the word the CPU is returning wins.
    assign bypass    = do_b & (mon_areg == rd_addr);

    assign waitrequest = (read | write) & ~(cpu_wr | (c_state == C_RD));
    assign readdata    = (c_state != C_RD) ? 32'h0
                       : bypass ? jdo_wdata : ram_q;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 4'h0;
        ram_addr  = mon_areg;
        ram_wdata = jdo_wdata;
        unique case (1'b1)
            do_a && jdo[JDO_RD_BIT]: begin
                ram_en   = 1'b1;
                ram_addr = jdo_addr;
            end
            do_b: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
                ram_be = 4'hF;
            end
            do_na: begin
                ram_en = 1'b1;
            end
            cpu_wr: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_be    = byteenable;
                ram_addr  = address;
                ram_wdata = writedata;
            end
            cpu_rd: begin
                ram_en   = 1'b1;
                ram_addr = address;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            j_state       <= J_IDLE;
            mon_areg      <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            unique case (j_state)
                J_IDLE: begin
                    if (do_a) begin
                        mon_areg      <= jdo_addr;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                        if (jdo[JDO_RD_BIT]) begin
                            j_state <= J_RD;
                        end
                    end else if (do_b) begin
                        mon_areg <= mon_areg + ADDR_W'(1);
                    end else if (do_na) begin
                        mon_areg      <= mon_areg + ADDR_W'(1);
                        monitor_ready <= 1'b0;
                        j_state       <= J_RD;
                    end
                end
                J_RD: begin
                    MonDReg       <= ram_q;
                    monitor_ready <= 1'b1;
                    j_state       <= J_IDLE;
                    if (any_pulse) begin
                        monitor_error <= 1'b1;
                    end
                end
                default: j_state <= J_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_state <= C_IDLE;
            rd_addr <= '0;
        end else begin
            unique case (c_state)
                C_IDLE: begin
                    if (cpu_rd) begin
                        c_state <= C_RD;
                        rd_addr <= address;
                    end
                end
                C_RD:    c_state <= C_IDLE;
                default: c_state <= C_IDLE;
            endcase
        end
    end

    nios2_system_nios2_ocimem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

endmodule

// File: tb/tb_nios2_system_nios2_ocimem_bridge.sv
// Scoreboard bench for the OCI debug-RAM bridge: JTAG and CPU reads
// queue expected words, a negedge monitor checks them as they appear.
module tb_nios2_system_nios2_ocimem_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        ta_a;
    logic        ta_b;
    logic        tna_a;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [7:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] jq[$];
    logic [31:0] cq[$];
    logic prev_rdy = 1'b0;

    nios2_system_nios2_ocimem_bridge #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tna_a),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .address                 (address),
        .read                    (read),
        .write                   (write),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .readdata                (readdata),
        .waitrequest             (waitrequest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (monitor_ready && !prev_rdy) begin
            if (jq.size() == 0) begin
                chk("jtag_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = jq.pop_front();
                chk("jtag_MonDReg", MonDReg, e);
            end
        end
        prev_rdy = monitor_ready;
        if (read && !waitrequest) begin
            if (cq.size() == 0) begin
                chk("cpu_unexpected_data", 32'd1, 32'd0);
            end else begin
                e = cq.pop_front();
                chk("cpu_readdata", readdata, e);
            end
        end
    end

    function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd);
        logic [37:0] v;
        v        = '0;
        v[24:17] = a;
        v[35]    = rd;
        return v;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] v;
        v       = '0;
        v[34:3] = d;
        return v;
    endfunction

    task automatic jcmd(input logic a, input logic b, input logic na,
                        input logic [37:0] j);
        jdo   = j;
        ta_a  = a;
        ta_b  = b;
        tna_a = na;
        @(posedge clk); #1;
        ta_a  = 1'b0;
        ta_b  = 1'b0;
        tna_a = 1'b0;
        jdo   = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic cpu_wait(input int start, output int cyc);
        cyc = start;
        while (cyc < 10) begin
            #3;
            if (!waitrequest) break;
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 10) chk("cpu_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [31:0] exp);
        int cyc;
        cq.push_back(exp);
        address = a;
        read    = 1'b1;
        cpu_wait(0, cyc);
        chk("cpu_read_latency", cyc, 1);
    endtask

    initial begin
        int cyc;
        reset_n    = 1'b0;
        jdo        = '0;
        ta_a       = 1'b0;
        ta_b       = 1'b0;
        tna_a      = 1'b0;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        byteenable = '0;
        idle(2);
        chk("rst_MonDReg", MonDReg, 32'h0);
        chk("rst_ready", {31'd0, monitor_ready}, 32'd0);
        chk("rst_error", {31'd0, monitor_error}, 32'd0);
        chk("rst_waitreq", {31'd0, waitrequest}, 32'd0);
        chk("rst_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        idle(1);

        // preload and JTAG read-on-load
        jcmd(1, 0, 0, mk_a(8'h10, 1'b0));
        jcmd(0, 1, 0, mk_b(32'hCAFEF00D));
        jcmd(1, 0, 0, mk_a(8'h01, 1'b0));
        jcmd(0, 1, 0, mk_b(32'h5A5A0101));
        jq.push_back(32'hCAFEF00D);
        jcmd(1, 0, 0, mk_a(8'h10, 1'b1));
        idle(1);

        // address wrap 0xFF -> 0x00 -> 0x01
        jcmd(1, 0, 0, mk_a(8'hFF, 1'b0));
        jcmd(0, 1, 0, mk_b(32'h11111111));
        jcmd(0, 1, 0, mk_b(32'h22222222));
        jq.push_back(32'h5A5A0101);
        jcmd(0, 0, 1, '0);
        idle(1);
        jq.push_back(32'h11111111);
        jcmd(1, 0, 0, mk_a(8'hFF, 1'b1));
        idle(1);
        jq.push_back(32'h22222222);
        jcmd(1, 0, 0, mk_a(8'h00, 1'b1));
        idle(1);

        // collision: b-pulse during J_RD is dropped and flags error
        jcmd(1, 0, 0, mk_a(8'h40, 1'b0));
        jcmd(0, 1, 0, mk_b(32'h40404040));
        jcmd(0, 1, 0, mk_b(32'h41414141));
        jcmd(1, 0, 0, mk_a(8'h40, 1'b0));
        jq.push_back(32'h40404040);
        jcmd(0, 0, 1, '0);
        jcmd(0, 1, 0, mk_b(32'hDEADBEEF));
        chk("collision_error", {31'd0, monitor_error}, 32'd1);
        jq.push_back(32'h41414141);
        jcmd(1, 0, 0, mk_a(8'h41, 1'b1));
        chk("error_cleared", {31'd0, monitor_error}, 32'd0);
        idle(1);

        // CPU read stalled by a same-cycle JTAG write
        jcmd(1, 0, 0, mk_a(8'h20, 1'b0));
        jcmd(0, 1, 0, mk_b(32'h20202020));
        cq.push_back(32'h20202020);
        address = 8'h20;
        read    = 1'b1;
        jdo     = mk_b(32'h77777777);
        ta_b    = 1'b1;
        #3;
        chk("cpu_stall_by_jtag", {31'd0, waitrequest}, 32'd1);
        @(posedge clk); #1;
        ta_b = 1'b0;
        jdo  = '0;
        cpu_wait(1, cyc);
        chk("cpu_stalled_latency", cyc, 2);

        // byte-enabled CPU write
        jcmd(1, 0, 0, mk_a(8'h30, 1'b0));
        jcmd(0, 1, 0, mk_b(32'h0));
        address    = 8'h30;
        writedata  = 32'hAABBCCDD;
        byteenable = 4'b0101;
        write      = 1'b1;
        #3;
        chk("cpu_write_nowait", {31'd0, waitrequest}, 32'd0);
        @(posedge clk); #1;
        write = 1'b0;
        cpu_read(8'h30, 32'h00BB00DD);

        // JTAG write then CPU read next cycle
        jcmd(1, 0, 0, mk_a(8'h50, 1'b0));
        jcmd(0, 1, 0, mk_b(32'h55AA55AA));
        cpu_read(8'h50, 32'h55AA55AA);

        // CPU read then JTAG write to same word next cycle
        jcmd(1, 0, 0, mk_a(8'h51, 1'b0));
        jcmd(0, 1, 0, mk_b(32'h00000001));
        jcmd(1, 0, 0, mk_a(8'h51, 1'b0));
        cq.push_back(32'h99999999);
        address = 8'h51;
        read    = 1'b1;
        @(posedge clk); #1;
        jdo  = mk_b(32'h99999999);
        ta_b = 1'b1;
        #3;
        chk("bypass_nowait", {31'd0, waitrequest}, 32'd0);
        @(posedge clk); #1;
        ta_b = 1'b0;
        jdo  = '0;
        read = 1'b0;
        jq.push_back(32'h99999999);
        jcmd(1, 0, 0, mk_a(8'h51, 1'b1));
        idle(1);

        // a + no_action_a together: a wins, no error
        jq.push_back(32'hCAFEF00D);
        jcmd(1, 0, 1, mk_a(8'h10, 1'b1));
        idle(1);
        chk("prio_no_error", {31'd0, monitor_error}, 32'd0);

        // reset during J_RD
        jcmd(1, 0, 0, mk_a(8'h40, 1'b0));
        jq.push_back(32'h40404040);
        jcmd(0, 0, 1, '0);
        jcmd(0, 0, 1, '0);
        chk("pre_reset_error", {31'd0, monitor_error}, 32'd1);
        jcmd(0, 0, 1, '0);
        reset_n = 1'b0;
        #2;
        chk("midrst_MonDReg", MonDReg, 32'h0);
        chk("midrst_ready", {31'd0, monitor_ready}, 32'd0);
        chk("midrst_error", {31'd0, monitor_error}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(1);
        jq.push_back(32'h22222222);
        jcmd(0, 0, 1, '0);
        idle(1);
        jq.push_back(32'hCAFEF00D);
        jcmd(1, 0, 0, mk_a(8'h10, 1'b1));
        idle(3);

        chk("jtag_queue_drained", jq.size(), 0);
        chk("cpu_queue_drained", cq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
